// File: rtl/dmem_mmio_responder_pkg.sv
// Shared definitions for the data-memory / MMIO responder: the MMIO page
// address, register offsets, STATUS bit positions and the access decoder.
package dmem_mmio_responder_pkg;

    localparam logic [23:0] MMIO_PAGE   = 24'hFFFFFF;
    localparam logic [7:0]  MMIO_TXDATA = 8'h00;
    localparam logic [7:0]  MMIO_STATUS = 8'h04;
    localparam logic [7:0]  MMIO_TIMER  = 8'h08;

    localparam int ST_EMPTY = 8;
    localparam int ST_FULL  = 9;
    localparam int ST_OVF   = 10;

    // Target selected by the current data-memory address
    typedef enum logic [2:0] {
        SEL_RAM    = 3'd0,
        SEL_TXDATA = 3'd1,
        SEL_STATUS = 3'd2,
        SEL_TIMER  = 3'd3,
        SEL_NONE   = 3'd4
    } mmio_sel_e;

    // Map a byte address to its target; the two low address bits never matter.
    function automatic mmio_sel_e decode_sel(input logic [31:0] addr);
        mmio_sel_e sel;
        if (addr[31:8] != MMIO_PAGE) begin
            sel = SEL_RAM;
        end else begin
            case ({addr[7:2], 2'b00})
                MMIO_TXDATA: sel = SEL_TXDATA;
                MMIO_STATUS: sel = SEL_STATUS;
                MMIO_TIMER:  sel = SEL_TIMER;
                default:     sel = SEL_NONE;
            endcase
        end
        return sel;
    endfunction

    // Assemble the STATUS word from the FIFO occupancy and the overflow flag.
    function automatic logic [31:0] pack_status(input logic [7:0] cnt,
                                                input logic       empty,
                                                input logic       full,
                                                input logic       ovf);
        logic [31:0] word;
        word           = 32'h0000_0000;
        word[7:0]      = cnt;
        word[ST_EMPTY] = empty;
        word[ST_FULL]  = full;
        word[ST_OVF]   = ovf;
        return word;
    endfunction

endpackage

// File: rtl/dmem_mmio_responder_if.sv
// CPU data-memory port plus the outgoing TX byte stream of the responder.
interface dmem_mmio_responder_if;

    logic        wmem;
    logic [31:0] mem_addr;
    logic [31:0] mem_datain;
    logic [31:0] mem_dataout;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;

    // CPU and byte consumer side
    modport master (
        output wmem, mem_addr, mem_datain, tx_ready,
        input  mem_dataout, tx_data, tx_valid
    );

    // Responder side
    modport slave (
        input  wmem, mem_addr, mem_datain, tx_ready,
        output mem_dataout, tx_data, tx_valid
    );

endinterface

// File: rtl/dmem_mmio_responder_tx_fifo.sv
// Byte FIFO feeding the TX stream. A push into a full FIFO is only taken
// when a pop happens in the same cycle; otherwise it is silently refused
// (the parent tracks overflow). Needs FIFO_AW >= 2.
module dmem_mmio_responder_tx_fifo #(
    parameter int FIFO_AW = 4
) (
    input  logic             clock,
    input  logic             resetn,
    input  logic             push,
    input  logic [7:0]       push_data,
    input  logic             pop,
    output logic [7:0]       head_data,
    output logic             head_valid,
    output logic             full,
    output logic             empty,
    output logic [FIFO_AW:0] count
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   CNT_FULL = {1'b1, {FIFO_AW{1'b0}}};
    localparam logic [FIFO_AW:0]   CNT_ONE  = {{FIFO_AW{1'b0}}, 1'b1};
    localparam logic [FIFO_AW-1:0] PTR_ONE  = {{(FIFO_AW-1){1'b0}}, 1'b1};

    logic [7:0]         mem_r [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr_r;
    logic [FIFO_AW-1:0] rd_ptr_r;
    logic [FIFO_AW:0]   count_r;
    logic               empty_s;
    logic               full_s;
    logic               pop_ok_s;
    logic               push_ok_s;

    assign empty_s   = (count_r == {(FIFO_AW+1){1'b0}});
    assign full_s    = (count_r == CNT_FULL);
    assign pop_ok_s  = pop & ~empty_s;
    assign push_ok_s = push & (~full_s | pop_ok_s);

    // Storage write; contents are don't-care until a pointer covers them
    always_ff @(posedge clock) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_r <= {FIFO_AW{1'b0}};
            rd_ptr_r <= {FIFO_AW{1'b0}};
            count_r  <= {(FIFO_AW+1){1'b0}};
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

    // Head byte reads as zero while nothing is queued
    always_comb begin
        head_data = 8'h00;
        if (empty_s) begin
            head_data = 8'h00;
        end else begin
            head_data = mem_r[rd_ptr_r];
        end
    end

    assign head_valid = ~empty_s;
    assign full       = full_s;
    assign empty      = empty_s;
    assign count      = count_r;

endmodule

// File: rtl/dmem_mmio_responder.sv
// Memory-side responder for the CPU data port: word RAM with zero-latency
// read, plus an MMIO page with a TX byte FIFO, STATUS and a cycle timer.
module dmem_mmio_responder
    import dmem_mmio_responder_pkg::*;
#(
    parameter int RAM_AW  = 10,
    parameter int FIFO_AW = 4
) (
    input  logic                  clock,
    input  logic                  resetn,
    dmem_mmio_responder_if.slave  bus
);

    localparam int RAM_WORDS = 1 << RAM_AW;

    logic [31:0]        ram_r [RAM_WORDS];
    logic [31:0]        timer_r;
    logic               ovf_r;

    mmio_sel_e          sel_s;
    logic [RAM_AW-1:0]  ram_idx_s;
    logic               ram_we_s;
    logic               push_s;
    logic               pop_s;
    logic               push_rej_s;
    logic               ovf_clr_s;
    logic               timer_ld_s;
    logic [7:0]         fifo_head_s;
    logic               fifo_valid_s;
    logic               fifo_full_s;
    logic               fifo_empty_s;
    logic [FIFO_AW:0]   fifo_count_s;
    logic [7:0]         status_cnt_s;
    logic [31:0]        rd_data_s;

    assign sel_s      = decode_sel(bus.mem_addr);
    assign ram_idx_s  = bus.mem_addr[RAM_AW+1:2];
    assign ram_we_s   = bus.wmem & (sel_s == SEL_RAM);
    assign push_s     = bus.wmem & (sel_s == SEL_TXDATA);
    assign pop_s      = fifo_valid_s & bus.tx_ready;
    assign push_rej_s = push_s & fifo_full_s & ~pop_s;
    assign ovf_clr_s  = bus.wmem & (sel_s == SEL_STATUS) & bus.mem_datain[ST_OVF];
    assign timer_ld_s = bus.wmem & (sel_s == SEL_TIMER);

    dmem_mmio_responder_tx_fifo #(
        .FIFO_AW (FIFO_AW)
    ) u_tx_fifo (
        .clock      (clock),
        .resetn     (resetn),
        .push       (push_s),
        .push_data  (bus.mem_datain[7:0]),
        .pop        (pop_s),
        .head_data  (fifo_head_s),
        .head_valid (fifo_valid_s),
        .full       (fifo_full_s),
        .empty      (fifo_empty_s),
        .count      (fifo_count_s)
    );

    // RAM write port; reads elsewhere see the pre-edge word
    always_ff @(posedge clock) begin
        if (ram_we_s) begin
            ram_r[ram_idx_s] <= bus.mem_datain;
        end
    end

    // Sticky overflow: set by a refused push, cleared by writing 1 to its STATUS bit
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            ovf_r <= 1'b0;
        end else if (push_rej_s) begin
            ovf_r <= 1'b1;
        end else if (ovf_clr_s) begin
            ovf_r <= 1'b0;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    // Free-running cycle timer; a CPU load takes priority over the increment
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            timer_r <= 32'h0000_0000;
        end else if (timer_ld_s) begin
            timer_r <= bus.mem_datain;
        end else begin
            timer_r <= timer_r + 32'h0000_0001;
        end
    end

    // Zero-extend the FIFO occupancy into the STATUS count field
    always_comb begin
        status_cnt_s                = 8'h00;
        status_cnt_s[FIFO_AW:0]     = fifo_count_s;
    end

    // Same-cycle read data selected by the address decode
    always_comb begin
        rd_data_s = 32'h0000_0000;
        case (sel_s)
            SEL_RAM:    rd_data_s = ram_r[ram_idx_s];
            SEL_STATUS: rd_data_s = pack_status(status_cnt_s, fifo_empty_s, fifo_full_s, ovf_r);
            SEL_TIMER:  rd_data_s = timer_r;
            default:    rd_data_s = 32'h0000_0000;
        endcase
    end

    assign bus.mem_dataout = rd_data_s;
    assign bus.tx_data     = fifo_head_s;
    assign bus.tx_valid    = fifo_valid_s;

endmodule

// File: tb/tb_dmem_mmio_responder.sv
// Bench for dmem_mmio_responder: a driver issues one access per cycle and
// queues the expected read data from a queue/array model; a monitor on the
// falling edge compares read data and the TX byte stream.
module tb_dmem_mmio_responder;

    import dmem_mmio_responder_pkg::*;

    localparam int RAM_AW  = 10;
    localparam int FIFO_AW = 4;
    localparam int DEPTH   = 16;
    localparam logic [31:0] A_TXDATA = 32'hFFFF_FF00;
    localparam logic [31:0] A_STATUS = 32'hFFFF_FF04;
    localparam logic [31:0] A_TIMER  = 32'hFFFF_FF08;

    logic clock  = 1'b0;
    logic resetn = 1'b0;

    dmem_mmio_responder_if bus ();

    dmem_mmio_responder #(
        .RAM_AW  (RAM_AW),
        .FIFO_AW (FIFO_AW)
    ) dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic        chk;
        logic [31:0] val;
        string       name;
    } exp_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc   = 0;
    exp_t        rd_q [$];
    logic [7:0]  tx_q [$];
    logic [31:0] ram_m [int];
    logic        ovf_m       = 1'b0;
    logic [31:0] tmr_load    = 32'h0;
    int          tmr_load_cyc = 0;
    logic        pend_push   = 1'b0;
    logic [7:0]  pend_byte   = 8'h00;

    always @(posedge clock) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] exp_status();
        int n;
        logic [31:0] w;
        n = tx_q.size();
        w = 32'h0;
        w[7:0] = 8'(n);
        w[8]   = (n == 0);
        w[9]   = (n == DEPTH);
        w[10]  = ovf_m;
        return w;
    endfunction

    // Monitor: compare read data and the TX stream each falling edge
    always @(negedge clock) begin : monitor
        exp_t e;
        if (resetn) begin
            if (rd_q.size() > 0) begin
                e = rd_q.pop_front();
                if (e.chk) check(e.name, bus.mem_dataout, e.val);
            end
            check("tx_valid", {31'b0, bus.tx_valid}, (tx_q.size() != 0) ? 32'd1 : 32'd0);
            if (bus.tx_valid && tx_q.size() != 0) begin
                check("tx_data", {24'b0, bus.tx_data}, {24'b0, tx_q[0]});
                if (bus.tx_ready) void'(tx_q.pop_front());
            end
        end
    end

    // One bus cycle: drive, predict, then step past the next rising edge
    task automatic op(input logic w, input logic [31:0] addr, input logic [31:0] data,
                      input logic rdy, input string nm);
        exp_t e;
        int n;
        int idx;
        logic [7:0] off;
        bus.wmem = w; bus.mem_addr = addr; bus.mem_datain = data; bus.tx_ready = rdy;
        n = tx_q.size();
        e.name = nm; e.chk = 1'b1; e.val = 32'h0;
        if (addr[31:8] == 24'hFFFFFF) begin
            off = {addr[7:2], 2'b00};
            if (off == 8'h04) e.val = exp_status();
            else if (off == 8'h08) e.val = tmr_load + 32'(cyc - tmr_load_cyc);
            if (w) begin
                if (off == 8'h00) begin
                    if (n < DEPTH || (rdy && n > 0)) begin
                        pend_push = 1'b1; pend_byte = data[7:0];
                    end else begin
                        ovf_m = 1'b1;
                    end
                end else if (off == 8'h04) begin
                    if (data[10]) ovf_m = 1'b0;
                end else if (off == 8'h08) begin
                    tmr_load = data; tmr_load_cyc = cyc + 1;
                end
            end
        end else begin
            idx = int'((addr >> 2) % 32'(1 << RAM_AW));
            if (ram_m.exists(idx)) e.val = ram_m[idx];
            else e.chk = 1'b0;
            if (w) ram_m[idx] = data;
        end
        rd_q.push_back(e);
        @(posedge clock);
        #1;
        if (pend_push) begin
            tx_q.push_back(pend_byte);
            pend_push = 1'b0;
        end
    endtask

    task automatic release_reset();
        resetn = 1'b1;
        tmr_load = 32'h0; tmr_load_cyc = cyc;
        ovf_m = 1'b0;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        logic [31:0] a;
        int r;
        bus.wmem = 1'b0; bus.mem_addr = A_TIMER; bus.mem_datain = 32'h0; bus.tx_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check("reset tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        check("reset tx_data", {24'b0, bus.tx_data}, 32'd0);
        check("reset timer", bus.mem_dataout, 32'd0);
        bus.mem_addr = A_STATUS;
        #1;
        check("reset status", bus.mem_dataout, 32'h0000_0100);
        release_reset();

        // RAM write/read and alias
        op(1'b1, 32'h40, 32'hDEADBEEF, 1'b0, "ram wr 40");
        op(1'b0, 32'h40, 32'h0, 1'b0, "ram rd 40");
        op(1'b0, 32'h40 + (32'd4 << RAM_AW), 32'h0, 1'b0, "ram alias 40");
        // Read during write returns old data
        op(1'b1, 32'h80, 32'd1, 1'b0, "ram wr 80");
        op(1'b1, 32'h80, 32'd2, 1'b0, "ram raw 80");
        op(1'b0, 32'h80, 32'h0, 1'b0, "ram rd 80");

        // Three pushes then drain
        op(1'b1, A_TXDATA, 32'h41, 1'b0, "push A");
        op(1'b1, A_TXDATA, 32'h42, 1'b0, "push B");
        op(1'b1, A_TXDATA, 32'h43, 1'b0, "push C");
        op(1'b0, A_STATUS, 32'h0, 1'b0, "status 3");
        for (int i = 0; i < 4; i++) op(1'b0, A_STATUS, 32'h0, 1'b1, "status drain");
        op(1'b0, A_TXDATA, 32'h0, 1'b1, "txdata rd");

        // Overflow, clear, push+pop on full, drain
        for (int i = 0; i < 17; i++) op(1'b1, A_TXDATA, 32'h10 + 32'(i), 1'b0, "push fill");
        op(1'b0, A_STATUS, 32'h0, 1'b0, "status full ovf");
        op(1'b1, A_STATUS, 32'h400, 1'b0, "status clr");
        op(1'b0, A_STATUS, 32'h0, 1'b0, "status after clr");
        op(1'b1, A_TXDATA, 32'h55, 1'b1, "push on full+pop");
        op(1'b0, A_STATUS, 32'h0, 1'b0, "status full no ovf");
        for (int i = 0; i < 17; i++) op(1'b0, A_STATUS, 32'h0, 1'b1, "status drain2");

        // Timer load and wrap
        op(1'b1, A_TIMER, 32'hFFFF_FFFE, 1'b0, "timer wr");
        op(1'b0, 32'h40, 32'h0, 1'b0, "ram rd idle");
        op(1'b0, A_TIMER, 32'h0, 1'b0, "timer wrap");
        op(1'b0, A_TIMER, 32'h0, 1'b0, "timer +1");
        op(1'b1, 32'hFFFF_FF3C, 32'h1234, 1'b0, "other wr");
        op(1'b0, 32'hFFFF_FF3C, 32'h0, 1'b0, "other rd");

        // Randomized traffic
        for (int i = 0; i < 600; i++) begin
            r = $urandom_range(0, 9);
            a = 32'h100 + (32'($urandom_range(0, 15)) << 2) + (32'($urandom_range(0, 3)) << (RAM_AW + 2));
            case (r)
                0, 1:    op(1'b1, a, $urandom, ($urandom_range(0, 2) == 0), "rnd ram wr");
                2:       op(1'b0, a, 32'h0, ($urandom_range(0, 2) == 0), "rnd ram rd");
                3, 4, 5: op(1'b1, A_TXDATA | 32'($urandom_range(0, 3)), $urandom, ($urandom_range(0, 2) == 0), "rnd push");
                6:       op(1'b0, A_STATUS, 32'h0, ($urandom_range(0, 2) == 0), "rnd status");
                7:       op(1'b1, A_STATUS, ($urandom_range(0, 1) == 0) ? 32'h400 : 32'h3FF, ($urandom_range(0, 2) == 0), "rnd status wr");
                8:       op(($urandom_range(0, 7) == 0), A_TIMER, $urandom, ($urandom_range(0, 2) == 0), "rnd timer");
                default: op($urandom_range(0, 1) == 1, 32'hFFFF_FF00 | (32'($urandom_range(3, 63)) << 2), $urandom, 1'b1, "rnd other");
            endcase
        end

        // Reset in the middle of a drain
        for (int i = 0; i < 6; i++) op(1'b1, A_TXDATA, 32'hA0 + 32'(i), 1'b0, "push pre-reset");
        op(1'b0, A_STATUS, 32'h0, 1'b1, "drain pre-reset");
        op(1'b0, A_STATUS, 32'h0, 1'b1, "drain pre-reset");
        #2;
        bus.wmem = 1'b0;
        resetn = 1'b0;
        tx_q.delete();
        pend_push = 1'b0;
        #1;
        check("async rst tx_valid", {31'b0, bus.tx_valid}, 32'd0);
        check("async rst tx_data", {24'b0, bus.tx_data}, 32'd0);
        bus.mem_addr = A_STATUS;
        #1;
        check("async rst status", bus.mem_dataout, 32'h0000_0100);
        bus.mem_addr = A_TIMER;
        #1;
        check("async rst timer", bus.mem_dataout, 32'd0);
        @(posedge clock);
        #1;
        release_reset();
        op(1'b0, A_TIMER, 32'h0, 1'b0, "timer after reset");
        op(1'b0, A_STATUS, 32'h0, 1'b1, "status after reset");
        op(1'b1, A_TXDATA, 32'h77, 1'b0, "push after reset");
        op(1'b0, A_STATUS, 32'h0, 1'b1, "status after push");
        op(1'b0, A_STATUS, 32'h0, 1'b1, "status drained");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
